sram_fb_writer: RTL

//  Single-clock SRAM controller in the SRAM clock domain, directly downstream of the pixel CDC FIFO.
//  - Pops pixel tokens (fb_addr, hit, bri, swap) and byte-writes them into the back buffer of a double-buffered 8bpp framebuffer in 1Mx16 async SRAM.
//  - Serves scanout word reads from the front buffer.
//  - Flips buffers on vblank after a swap token.

---
 rtl/sram_fb_writer_if.sv | 45 ++++
 rtl/sram_fb_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fb_writer_if.sv
// Pixel-token stream, scanout read port, video-timing input and SRAM pin
// bundle of sram_fb_writer. The slave modport is the controller's view.
interface sram_fb_writer_if;
  // pixel token stream from the CDC FIFO
  logic [19:0] fb_addr_i;
  logic        hit_i;
  logic [7:0]  bri_i;
  logic        swap_i;
  logic        valid_i;
  logic        ready_o;
  // video timing and scanout read port
  logic        vblank_i;
  logic        rd_req_i;
  logic [18:0] rd_addr_i;
  logic        rd_busy_o;
  logic [15:0] rd_data_o;
  logic        rd_valid_o;
  logic        front_buf_o;
  // async SRAM pins
  logic [19:0] sram_addr_o;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe_o;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic        sram_ub_n_o;
  logic        sram_lb_n_o;

  modport slave (
    input  fb_addr_i, hit_i, bri_i, swap_i, valid_i, vblank_i,
           rd_req_i, rd_addr_i, sram_dq_i,
    output ready_o, rd_busy_o, rd_data_o, rd_valid_o, front_buf_o,
           sram_addr_o, sram_dq_o, sram_dq_oe_o, sram_ce_n_o,
           sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o
  );

  modport master (
    output fb_addr_i, hit_i, bri_i, swap_i, valid_i, vblank_i,
           rd_req_i, rd_addr_i, sram_dq_i,
    input  ready_o, rd_busy_o, rd_data_o, rd_valid_o, front_buf_o,
           sram_addr_o, sram_dq_o, sram_dq_oe_o, sram_ce_n_o,
           sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o
  );
endinterface

// File: rtl/sram_fb_writer.sv
// Double-buffered 8bpp framebuffer controller for a 1Mx16 async SRAM.
// Byte-writes pixel tokens into the back buffer, serves scanout word reads
// from the front buffer (reads win over writes) and flips buffers on the
// first vblank rising edge after a swap token has been written.
module sram_fb_writer #(
  parameter logic [7:0] BG_BRI      = 8'h00,
  parameter int         WRITE_PULSE = 2,
  parameter int         READ_WAIT   = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  sram_fb_writer_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_SETUP = 3'd1;
  localparam logic [2:0] S_WR_PULSE = 3'd2;
  localparam logic [2:0] S_WR_HOLD  = 3'd3;
  localparam logic [2:0] S_RD       = 3'd4;

  localparam logic [7:0] WP_LOAD = 8'(WRITE_PULSE - 1);
  localparam logic [7:0] RW_LOAD = 8'(READ_WAIT - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic        tok_swap;
  logic        front_buf;
  logic        swap_pending;
  logic        vb_sync, vb_prev;
  logic        rd_pend;
  logic [18:0] rd_addr_q;
  logic        rd_cap;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq;
  logic        sram_dq_oe;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  logic       ready;
  logic       pop;
  logic       rd_done;
  logic       vb_rise;
  logic [7:0] pix;

  assign ready   = (state == S_IDLE) && !swap_pending && !rd_pend && !rst_i;
  assign pop     = bus.valid_i && ready;
  assign rd_done = (state == S_RD) && (cnt == 8'd0);
  assign vb_rise = vb_sync && !vb_prev;
  assign pix     = bus.hit_i ? bus.bri_i : BG_BRI;

  // Read port: latch one request at a time; busy until the word is captured.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
    end else if (bus.rd_req_i && !rd_pend) begin
      rd_pend   <= 1'b1;
      rd_addr_q <= bus.rd_addr_i;
    end else if (rd_done) begin
      rd_pend <= 1'b0;
    end
  end

  // Read return: capture SRAM data at the end of RD, strobe valid one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cap   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_cap   <= rd_done;
      rd_valid <= rd_cap;
      if (rd_done) rd_data <= bus.sram_dq_i;
    end
  end

  // Buffer flip: vblank is resynchronised, then its rising edge commits a pending swap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vb_sync      <= 1'b0;
      vb_prev      <= 1'b0;
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      vb_sync <= bus.vblank_i;
      vb_prev <= vb_sync;
      if (vb_rise && swap_pending) begin
        front_buf    <= ~front_buf;
        swap_pending <= 1'b0;
      end else if (state == S_WR_HOLD && tok_swap) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // SRAM sequencer: every pin is registered; ce_n is low in all non-IDLE states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tok_swap   <= 1'b0;
      sram_addr  <= '0;
      sram_dq    <= '0;
      sram_dq_oe <= 1'b0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      ub_n       <= 1'b1;
      lb_n       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_pend) begin
            state      <= S_RD;
            cnt        <= RW_LOAD;
            sram_addr  <= {front_buf, rd_addr_q};
            sram_dq_oe <= 1'b0;
            ce_n       <= 1'b0;
            oe_n       <= 1'b0;
            ub_n       <= 1'b0;
            lb_n       <= 1'b0;
          end else if (pop) begin
            state      <= S_WR_SETUP;
            tok_swap   <= bus.swap_i;
            sram_addr  <= {~front_buf, bus.fb_addr_i[19:1]};
            sram_dq    <= {pix, pix};
            sram_dq_oe <= 1'b1;
            ce_n       <= 1'b0;
            oe_n       <= 1'b1;
            we_n       <= 1'b1;
            lb_n       <= bus.fb_addr_i[0];
            ub_n       <= ~bus.fb_addr_i[0];
          end
        end
        S_WR_SETUP: begin
          state <= S_WR_PULSE;
          cnt   <= WP_LOAD;
          we_n  <= 1'b0;
        end
        S_WR_PULSE: begin
          if (cnt == 8'd0) begin
            state <= S_WR_HOLD;
            we_n  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_WR_HOLD: begin
          state      <= S_IDLE;
          sram_dq_oe <= 1'b0;
          ce_n       <= 1'b1;
          ub_n       <= 1'b1;
          lb_n       <= 1'b1;
        end
        S_RD: begin
          if (cnt == 8'd0) begin
            state <= S_IDLE;
            ce_n  <= 1'b1;
            oe_n  <= 1'b1;
            ub_n  <= 1'b1;
            lb_n  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o      = ready;
  assign bus.rd_busy_o    = rd_pend;
  assign bus.rd_data_o    = rd_data;
  assign bus.rd_valid_o   = rd_valid;
  assign bus.front_buf_o  = front_buf;
  assign bus.sram_addr_o  = sram_addr;
  assign bus.sram_dq_o    = sram_dq;
  assign bus.sram_dq_oe_o = sram_dq_oe;
  assign bus.sram_ce_n_o  = ce_n;
  assign bus.sram_oe_n_o  = oe_n;
  assign bus.sram_we_n_o  = we_n;
  assign bus.sram_ub_n_o  = ub_n;
  assign bus.sram_lb_n_o  = lb_n;

endmodule
